// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader and combinational fetch port for the instruction RAM
module imem_loader #(
    parameter int          DEPTH    = 32,
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [31:0]       pc,
    output logic [31:0]       instruction,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] ERROR = 3'd4;

    logic [2:0]        state;
    logic [7:0]        count;
    logic [7:0]        checksum;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [23:0]       shift_reg;
    logic [31:0]       mem [DEPTH];

    logic accept;
    logic pc_unused;

    assign accept      = rx_valid && rx_ready;
    assign instruction = mem[pc[ADDR_W+1:2]];
    assign pc_unused   = &{1'b0, pc[31:ADDR_W+2], pc[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rx_ready     <= 1'b1;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            count        <= '0;
            checksum     <= '0;
            byte_idx     <= '0;
            word_idx     <= '0;
            shift_reg    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP_WORD;
            end
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (rx_data == 8'd0 || {1'b0, rx_data} > 9'(DEPTH)) begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                        rx_ready   <= 1'b0;
                    end else begin
                        count    <= rx_data;
                        checksum <= rx_data;
                        byte_idx <= '0;
                        word_idx <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    checksum <= checksum ^ rx_data;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        // Last byte of the word lands directly in the top lane.
                        mem[word_idx] <= {rx_data, shift_reg};
                        word_idx      <= word_idx + ADDR_W'(1);
                        words_loaded  <= words_loaded + (ADDR_W+1)'(1);
                        if (9'(word_idx) + 9'd1 == {1'b0, count}) begin
                            state <= CHECK;
                        end
                    end else begin
                        shift_reg <= {rx_data, shift_reg[23:8]};
                    end
                end
                CHECK: begin
                    rx_ready <= 1'b0;
                    if (rx_data == checksum) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule
